// File: rtl/zuma_config_loader.sv
// ZUMA overlay configuration loader: walks the bitstream ROM and streams bit-reversed words into the fabric.
// Optional build macro ZUMA_CFG_CHECKSUM_EN adds a running-sum check of the loaded words against expected_sum.
module zuma_config_loader #(
  parameter int NUM_WORDS  = 1024,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [DATA_WIDTH-1:0] config_data,
  output logic                  config_en,
  output logic [ADDR_WIDTH-1:0] config_addr,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] progress
`ifdef ZUMA_CFG_CHECKSUM_EN
  ,
  input  logic [DATA_WIDTH-1:0] expected_sum,
  output logic                  sum_err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_WIDTH-1:0] config_addr_q, config_addr_d;
  logic [ADDR_WIDTH-1:0] progress_q, progress_d;
  logic                  config_en_q, config_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
`ifdef ZUMA_CFG_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic                  sum_err_q, sum_err_d;
`endif

  // The ROM registers its read, so mem_q already lines up with config_en/config_addr.
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_rev
    assign config_data[DATA_WIDTH-1-i] = mem_q[i];
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d       = state_q;
    mem_addr_d    = mem_addr_q;
    config_addr_d = config_addr_q;
    progress_d    = progress_q;
    config_en_d   = config_en_q;
    busy_d        = busy_q;
    done_d        = done_q;
`ifdef ZUMA_CFG_CHECKSUM_EN
    sum_d         = sum_q;
    sum_err_d     = sum_err_q;
`endif

    // A word is written into the fabric on every edge where the strobe is high.
    if (config_en_q) begin
      progress_d = progress_q + ADDR_WIDTH'(1);
`ifdef ZUMA_CFG_CHECKSUM_EN
      sum_d      = sum_q + mem_q;
`endif
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_READ;
          mem_addr_d  = '0;
          done_d      = 1'b0;
          busy_d      = 1'b1;
          progress_d  = '0;
          config_en_d = 1'b0;
`ifdef ZUMA_CFG_CHECKSUM_EN
          sum_d       = '0;
          sum_err_d   = 1'b0;
`endif
        end
      end
      S_READ: begin
        if (abort) begin
          state_d     = S_IDLE;
          config_en_d = 1'b0;
          busy_d      = 1'b0;
`ifdef ZUMA_CFG_CHECKSUM_EN
          sum_err_d   = 1'b0;
`endif
        end else begin
          config_en_d   = 1'b1;
          config_addr_d = mem_addr_q;
          // The final address holds rather than wrapping once it has been retired.
          if (mem_addr_q == LAST_ADDR) state_d = S_DRAIN;
          else mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
        end
      end
      S_DRAIN: begin
        state_d     = abort ? S_IDLE : S_DONE;
        config_en_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = !abort;
`ifdef ZUMA_CFG_CHECKSUM_EN
        sum_err_d   = abort ? 1'b0 : (sum_d != expected_sum);
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: every register, including the datapath, is reset so an async reset drops config_en at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state is assigned with <= so all flops update from pre-edge values.
      state_q       <= S_IDLE;
      mem_addr_q    <= '0;
      config_addr_q <= '0;
      progress_q    <= '0;
      config_en_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef ZUMA_CFG_CHECKSUM_EN
      sum_q         <= '0;
      sum_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      mem_addr_q    <= mem_addr_d;
      config_addr_q <= config_addr_d;
      progress_q    <= progress_d;
      config_en_q   <= config_en_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
`ifdef ZUMA_CFG_CHECKSUM_EN
      sum_q         <= sum_d;
      sum_err_q     <= sum_err_d;
`endif
    end
  end

  assign mem_addr    = mem_addr_q;
  assign config_addr = config_addr_q;
  assign progress    = progress_q;
  assign config_en   = config_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
`ifdef ZUMA_CFG_CHECKSUM_EN
  assign sum_err     = sum_err_q;
`endif

endmodule

// File: tb/tb_zuma_config_loader.sv
// Directed self-checking bench for zuma_config_loader with an 8-word ROM holding word n = n.
// Checksum scenarios are compiled in when ZUMA_CFG_CHECKSUM_EN is defined.
module tb_zuma_config_loader;

  localparam int NW = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_q = '0;
  logic [31:0] config_data;
  logic        config_en;
  logic [31:0] config_addr;
  logic        busy;
  logic        done;
  logic [31:0] progress;
`ifdef ZUMA_CFG_CHECKSUM_EN
  logic [31:0] expected_sum = '0;
  logic        sum_err;
`endif

  int checks = 0;
  int errors = 0;

  zuma_config_loader #(.NUM_WORDS(NW), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .mem_addr    (mem_addr),
    .mem_q       (mem_q),
    .config_data (config_data),
    .config_en   (config_en),
    .config_addr (config_addr),
    .busy        (busy),
    .done        (done),
    .progress    (progress)
`ifdef ZUMA_CFG_CHECKSUM_EN
    ,
    .expected_sum(expected_sum),
    .sum_err     (sum_err)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous ROM, one-cycle latency, word n = n.
  always @(posedge clk) mem_q <= mem_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[31-i] = x[i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic count_strobes(input int n, output int strobes);
    strobes = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (config_en) strobes++;
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check("done_within_budget", {31'b0, done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          s;
    logic [31:0] word1;

    do_reset();
    check("rst_config_en", {31'b0, config_en}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_progress", progress, 32'd0);
    check("rst_config_addr", config_addr, 32'd0);

    // Basic load: start at edge 0, strobes in cycles 1..8, done at edge 9.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ld_busy_e0", {31'b0, busy}, 32'd1);
    check("ld_en_e0", {31'b0, config_en}, 32'd0);
    check("ld_addr_e0", mem_addr, 32'd0);
    word1 = '0;
    for (int c = 1; c <= NW; c++) begin
      tick();
      check("ld_en", {31'b0, config_en}, 32'd1);
      check("ld_cfg_addr", config_addr, 32'(c - 1));
      check("ld_cfg_data", config_data, rev32(32'(c - 1)));
      check("ld_done_low", {31'b0, done}, 32'd0);
      if (c == 2) word1 = config_data;
    end
    check("ld_word1_rev", word1, 32'h8000_0000);
    tick();
    check("ld_en_off", {31'b0, config_en}, 32'd0);
    check("ld_done", {31'b0, done}, 32'd1);
    check("ld_busy_off", {31'b0, busy}, 32'd0);
    check("ld_progress", progress, 32'd8);
    check("ld_mem_addr_hold", mem_addr, 32'd7);

    // Abort at edge 4: three words written, everything holds, back in IDLE.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_en", {31'b0, config_en}, 32'd0);
    check("ab_busy", {31'b0, busy}, 32'd0);
    check("ab_done", {31'b0, done}, 32'd0);
    check("ab_progress", progress, 32'd3);
    check("ab_mem_addr", mem_addr, 32'd3);
    count_strobes(4, s);
    check("ab_idle_strobes", 32'(s), 32'd0);
    check("ab_idle_busy", {31'b0, busy}, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ab_restart_addr", mem_addr, 32'd0);
    tick();
    check("ab_restart_en", {31'b0, config_en}, 32'd1);
    check("ab_restart_cfg_addr", config_addr, 32'd0);
    wait_done(20);
    check("ab_restart_progress", progress, 32'd8);

    // Asynchronous reset in the middle of cycle 3.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    #2 reset = 1'b0;
    #1;
    check("ar_en", {31'b0, config_en}, 32'd0);
    check("ar_busy", {31'b0, busy}, 32'd0);
    check("ar_mem_addr", mem_addr, 32'd0);
    check("ar_progress", progress, 32'd0);
    check("ar_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    count_strobes(5, s);
    check("ar_no_strobes", 32'(s), 32'd0);

    // start held throughout the load is ignored once busy.
    start = 1'b1;
    tick();
    count_strobes(NW, s);
    start = 1'b0;
    tick();
    if (config_en) s++;
    check("hold_strobes", 32'(s), 32'd8);
    check("hold_done", {31'b0, done}, 32'd1);
    check("hold_progress", progress, 32'd8);

    // Restart from DONE.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rs_done_drop", {31'b0, done}, 32'd0);
    check("rs_busy", {31'b0, busy}, 32'd1);
    check("rs_mem_addr", mem_addr, 32'd0);
    count_strobes(NW + 1, s);
    check("rs_strobes", 32'(s), 32'd8);
    check("rs_done", {31'b0, done}, 32'd1);

    // Simultaneous start and abort in IDLE: start wins.
    do_reset();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("sa_busy", {31'b0, busy}, 32'd1);
    tick();
    check("sa_en_c1", {31'b0, config_en}, 32'd1);
    check("sa_cfg_addr_c1", config_addr, 32'd0);
    wait_done(20);

`ifdef ZUMA_CFG_CHECKSUM_EN
    expected_sum = 32'd28;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("cs_clear_on_start", {31'b0, sum_err}, 32'd0);
    wait_done(20);
    check("cs_match", {31'b0, sum_err}, 32'd0);
    expected_sum = 32'd29;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(20);
    check("cs_mismatch", {31'b0, sum_err}, 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("cs_err_cleared", {31'b0, sum_err}, 32'd0);
    wait_done(20);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/zuma_config_loader.md
# zuma_config_loader

Sequences the ZUMA overlay's configuration load. On a start request it walks a synchronous configuration ROM (one-cycle read latency) from address 0 to `NUM_WORDS-1`, bit-reverses each word, and streams it into the generated fabric's configuration port (`config_data`, `config_en`, `config_addr`) at one word per cycle. It sits between the bitstream ROM and the fabric in the test and top-level wrappers. It replaces free-running write/address counting with a start/busy/done handshake, an abort path and progress reporting.

## Interface
- `NUM_WORDS`, default 1024: number of configuration words to load; must be ≥ 2.
- `ADDR_WIDTH`, default 32: width of ROM and fabric addresses.
- `DATA_WIDTH`, default 32: configuration word width.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: load request; sampled only in IDLE or DONE.
- `abort` in 1: cancels a load in progress.
- `mem_addr` out `ADDR_WIDTH`: ROM read address.
- `mem_q` in `DATA_WIDTH`: ROM data; valid one cycle after `mem_addr`.
- `config_data` out `DATA_WIDTH`: `mem_q` bit-reversed, so `config_data[DATA_WIDTH-1-i] = mem_q[i]`.
- `config_en` out 1: fabric write strobe.
- `config_addr` out `ADDR_WIDTH`: address of the word on `config_data`.
- `busy` out 1: load in progress.
- `done` out 1: last load completed; level output.
- `progress` out `ADDR_WIDTH`: count of words written in the current load.

## Operation
- States:
  - IDLE: waiting for a request.
  - READ: issuing ROM addresses.
  - DRAIN: last ROM read in flight.
  - DONE: load complete.
- IDLE/DONE → READ when `start`=1 at a clock edge:
  - `mem_addr` ← 0; `done` ← 0; `busy` ← 1; `progress` ← 0.
- READ, on each edge:
  - `mem_addr` increments by 1.
  - Valid stage captures the previous address: `config_en` ← 1, `config_addr` ← previous `mem_addr`.
  - Leave for DRAIN on the edge where `mem_addr` = `NUM_WORDS-1` is retired, i.e. once the final address has been issued.
- DRAIN → DONE after one edge. That edge presents the final word with `config_en`=1.
- Leaving DRAIN: `config_en` ← 0; `busy` ← 0; `done` ← 1.
- `progress` increments on every edge where `config_en`=1.
- `mem_addr` holds at `NUM_WORDS-1` after the final issue and never wraps.
- `config_data` is combinational from `mem_q`. It is meaningful only while `config_en`=1.
- `abort`=1 in READ or DRAIN, at an edge:
  - Next state IDLE; `config_en` ← 0; `busy` ← 0; `done` stays 0.
  - `mem_addr` and `progress` hold their last values until the next start.
- `abort` and `start` together in IDLE/DONE: `start` wins. `abort` is ignored outside READ/DRAIN.
- `start` while busy: ignored.
- Asynchronous reset mid-load: immediate IDLE, with every output at its reset value. The fabric sees `config_en` drop in the same cycle.

Reset values: state IDLE; `mem_addr`, `config_addr` and `progress` = 0; `config_en`, `busy` and `done` = 0.

## Timing
- `start` sampled at edge 0.
- `config_en`=1 during cycles 1 through `NUM_WORDS`, with `config_addr` = cycle-1.
- `done`=1 from edge `NUM_WORDS`+1 onward.
- Throughput: one word per cycle with no gaps.
- Start-to-first-strobe latency: 1 cycle.
- Total load time: `NUM_WORDS`+1 cycles.
- Restart from DONE: `start` at edge k gives the first `config_en` in cycle k+1 and drops `done` at edge k.

## Configuration
- Macro: `ZUMA_CFG_CHECKSUM_EN`.
- Defined:
  - Adds input `expected_sum` (`DATA_WIDTH`) and output `sum_err` (1, reset 0).
  - Maintains a running mod-2^`DATA_WIDTH` sum of un-reversed `mem_q` words, counted on each `config_en` cycle and cleared on start.
  - On entry to DONE, `sum_err` ← (sum ≠ `expected_sum`).
  - `sum_err` is cleared on start, on abort and on reset.
- Undefined: the ports and the sum logic are absent; behaviour is otherwise identical.

## Test plan
- Basic load:
  - Stimulus: `NUM_WORDS`=8, ROM word n = n, `start` at edge 0.
  - Required: `config_en` high for cycles 1–8; `config_addr` 0..7; `config_data` = bit-reverse(n), e.g. word 1 → 0x80000000; `done` rises at edge 9; `progress`=8.
- Abort:
  - Stimulus: `abort` at edge 4.
  - Required: `config_en` low from cycle 4; `busy`=0; `done`=0; state IDLE.
  - Follow-up: a new `start` restarts from address 0.
- Asynchronous reset:
  - Stimulus: drop `reset` mid-cycle 3.
  - Required: `config_en`, `busy`, `mem_addr` and `progress` go to 0 immediately; no strobes after release until `start`.
- Restart and ignored start:
  - `start` held during the load: ignored, only 8 strobes.
  - `start` in DONE: `done` drops and a second full load of 8 strobes follows.
- Simultaneous `start` and `abort` in IDLE: load begins with `config_en` in cycle 1.
- With `ZUMA_CFG_CHECKSUM_EN`, ROM 0..7 (sum = 28):
  - `expected_sum`=28 → `sum_err`=0 at DONE.
  - `expected_sum`=29 → `sum_err`=1.
